// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory port: access size encodings,
// FSM state type, default bus timeout and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } memState_e;

    // Illegal size 2'b11 is reported as misaligned so it never reaches the bus.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addrLow[0];
            SZ_WORD: ok = (addrLow == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian bus: byte enables, store-data
// replication and load-data shift with sign/zero extension. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        addrLow_i,
    input  logic              isSigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rword_i,
    output logic [3:0]        byteEn_o,
    output logic [DATA_W-1:0] wdataRep_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        byteEn_o   = 4'b0000;
        wdataRep_o = '0;
        case (size_i)
            SZ_BYTE: begin
                byteEn_o   = 4'b0001 << addrLow_i;
                wdataRep_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                byteEn_o   = 4'b0011 << addrLow_i;
                wdataRep_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                byteEn_o   = 4'b1111;
                wdataRep_o = wdata_i;
            end
            default: begin
                byteEn_o   = 4'b0000;
                wdataRep_o = '0;
            end
        endcase
    end

    // The addressed byte/half is moved down to bit 0 before extension.
    always_comb begin
        shifted = rword_i >> {addrLow_i, 3'b000};
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{isSigned_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_o = {{16{isSigned_i & shifted[15]}}, shifted[15:0]};
            SZ_WORD: rdata_o = shifted;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_port.sv
// MEM-stage data-memory port: req/ack bus handshake with sized, aligned loads/stores,
// misalignment detection and a bus timeout; stalls the pipeline while an access is in flight.
module pipeline_mem_port
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iValid,
    input  logic              iRead,
    input  logic              iWrite,
    input  logic [1:0]        iSize,
    input  logic              iSigned,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iWriteData,
    output logic              oStall,
    output logic              oValid,
    output logic [DATA_W-1:0] oReadData,
    output logic              oMisaligned,
    output logic              oBusError,
    output logic              oBusReq,
    output logic              oBusWe,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [3:0]        oBusByteEn,
    output logic [DATA_W-1:0] oBusWData,
    input  logic              iBusAck,
    input  logic [DATA_W-1:0] iBusRData,
    input  logic              iBusErr
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    memState_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              isSigned_q, isSigned_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accessReq;
    logic              aligned;
    logic [3:0]        laneByteEn;
    logic [DATA_W-1:0] laneWData;
    logic [DATA_W-1:0] laneRData;

    mem_lane_align #(
        .DATA_W(DATA_W)
    ) u_lane (
        .size_i    (size_q),
        .addrLow_i (addr_q[1:0]),
        .isSigned_i(isSigned_q),
        .wdata_i   (wdata_q),
        .rword_i   (rdata_q),
        .byteEn_o  (laneByteEn),
        .wdataRep_o(laneWData),
        .rdata_o   (laneRData)
    );

    // Gating with reset keeps every output low while reset is held, even with iValid high.
    assign accessReq = iValid & (iRead | iWrite) & reset;
    assign aligned   = isAligned(iSize, iAddr[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            isSigned_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            isSigned_q <= isSigned_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        size_d      = size_q;
        isSigned_d  = isSigned_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        oStall      = 1'b0;
        oValid      = 1'b0;
        oReadData   = '0;
        oMisaligned = 1'b0;
        oBusError   = 1'b0;
        oBusReq     = 1'b0;
        oBusWe      = 1'b0;
        oBusAddr    = '0;
        oBusByteEn  = 4'b0000;
        oBusWData   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accessReq && aligned) begin
                    oStall     = 1'b1;
                    addr_d     = iAddr;
                    size_d     = iSize;
                    isSigned_d = iSigned;
                    we_d       = iWrite;
                    wdata_d    = iWriteData;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end else if (accessReq) begin
                    oMisaligned = 1'b1;
                end
            end
            ST_BUSY: begin
                oStall     = 1'b1;
                oBusReq    = 1'b1;
                oBusWe     = we_q;
                oBusAddr   = {addr_q[ADDR_W-1:2], 2'b00};
                oBusByteEn = laneByteEn;
                oBusWData  = laneWData;
                // An ack in the final counted cycle still wins over the timeout.
                if (iBusAck) begin
                    rdata_d = iBusRData;
                    err_d   = iBusErr;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                oValid    = 1'b1;
                oBusError = err_q;
                oReadData = we_q ? '0 : laneRData;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_mem_port.sv
// Directed self-checking bench for pipeline_mem_port with a hand-driven bus responder.
module tb_pipeline_mem_port;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        iValid, iRead, iWrite, iSigned;
    logic [1:0]  iSize;
    logic [31:0] iAddr, iWriteData;
    logic        oStall, oValid, oMisaligned, oBusError, oBusReq, oBusWe;
    logic [31:0] oReadData, oBusAddr, oBusWData;
    logic [3:0]  oBusByteEn;
    logic        iBusAck, iBusErr;
    logic [31:0] iBusRData;

    int checks = 0;
    int errors = 0;

    int          obsStall, obsReq;
    logic        obsDone, obsBusErr, obsWe;
    logic [31:0] obsRData, obsAddr, obsWData;
    logic [3:0]  obsBe;

    pipeline_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .iValid(iValid), .iRead(iRead), .iWrite(iWrite), .iSize(iSize), .iSigned(iSigned),
        .iAddr(iAddr), .iWriteData(iWriteData),
        .oStall(oStall), .oValid(oValid), .oReadData(oReadData), .oMisaligned(oMisaligned),
        .oBusError(oBusError), .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr),
        .oBusByteEn(oBusByteEn), .oBusWData(oBusWData),
        .iBusAck(iBusAck), .iBusRData(iBusRData), .iBusErr(iBusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one access starting in an IDLE cycle, acks on the ackAt-th BUSY cycle
    // (0 = never) and records what the port presented. Bounded to 40 cycles.
    task automatic runAccess(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ackAt, input logic [31:0] rdata, input logic err,
                             input logic lateAck);
        obsStall = 0; obsReq = 0; obsDone = 1'b0; obsBusErr = 1'b0; obsWe = 1'b0;
        obsRData = '0; obsAddr = '0; obsWData = '0; obsBe = '0;
        iValid = 1'b1; iRead = rd; iWrite = wr; iSize = sz; iSigned = sgn;
        iAddr = addr; iWriteData = wdata;
        for (int c = 0; c < 40 && !obsDone; c++) begin
            #2;
            if (oStall) obsStall++;
            if (oBusReq) begin
                obsReq++;
                if (obsReq == 1) begin
                    obsWe = oBusWe; obsAddr = oBusAddr; obsBe = oBusByteEn; obsWData = oBusWData;
                end
                if (obsReq == ackAt) begin
                    iBusAck = 1'b1; iBusRData = rdata; iBusErr = err;
                end
            end
            if (oValid) begin
                obsDone = 1'b1; obsRData = oReadData; obsBusErr = oBusError;
                iValid = 1'b0; iRead = 1'b0; iWrite = 1'b0;
                if (lateAck) begin
                    iBusAck = 1'b1; iBusRData = 32'h12345678;
                end
            end
            @(posedge clk); #1;
            if (!(obsDone && lateAck)) begin
                iBusAck = 1'b0; iBusErr = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        iValid = 1'b0; iRead = 1'b0; iWrite = 1'b0; iSize = SZ_WORD; iSigned = 1'b0;
        iAddr = '0; iWriteData = '0; iBusAck = 1'b0; iBusErr = 1'b0; iBusRData = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oStall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", oStall); end
        checks++; if (oBusReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", oBusReq); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", oValid); end
        checks++; if (oReadData !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h expected 0", oReadData); end
        checks++; if ({oMisaligned, oBusError, oBusWe, oBusByteEn} !== 7'b0) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0", {oMisaligned, oBusError, oBusWe, oBusByteEn}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++; if (obsDone !== 1'b1) begin errors++; $display("[TB] FAIL lw_done got %b expected 1", obsDone); end
        checks++; if (obsStall != 4) begin errors++; $display("[TB] FAIL lw_stall_cycles got %0d expected 4", obsStall); end
        checks++; if (obsReq != 3) begin errors++; $display("[TB] FAIL lw_req_cycles got %0d expected 3", obsReq); end
        checks++; if (obsRData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_rdata got %h expected deadbeef", obsRData); end
        checks++; if (obsBe !== 4'b1111) begin errors++; $display("[TB] FAIL lw_byteen got %b expected 1111", obsBe); end
        checks++; if (obsAddr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr got %h expected 00000100", obsAddr); end
        checks++; if ({obsWe, obsBusErr} !== 2'b00) begin errors++; $display("[TB] FAIL lw_we_err got %b expected 00", {obsWe, obsBusErr}); end
    endtask

    task automatic test_subword_load;
        runAccess(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 1, 32'h80112233, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_signed got %h expected ffffff80", obsRData); end
        checks++; if (obsBe !== 4'b1000) begin errors++; $display("[TB] FAIL lb_byteen got %b expected 1000", obsBe); end
        checks++; if (obsStall != 2) begin errors++; $display("[TB] FAIL lb_stall_cycles got %0d expected 2", obsStall); end
        runAccess(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 1, 32'h80112233, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu got %h expected 00000080", obsRData); end
        runAccess(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 1, 32'h80112233, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'h00000022) begin errors++; $display("[TB] FAIL lb_lane1 got %h expected 00000022", obsRData); end
        runAccess(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 2, 32'h80112233, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'hFFFF8011) begin errors++; $display("[TB] FAIL lh_signed got %h expected ffff8011", obsRData); end
        runAccess(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 1, 32'h80112233, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'h00008011) begin errors++; $display("[TB] FAIL lhu got %h expected 00008011", obsRData); end
    endtask

    task automatic test_store;
        runAccess(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000ABCD, 1, 32'hFFFFFFFF, 1'b0, 1'b0);
        checks++; if (obsAddr !== 32'h100) begin errors++; $display("[TB] FAIL sh_addr got %h expected 00000100", obsAddr); end
        checks++; if (obsBe !== 4'b1100) begin errors++; $display("[TB] FAIL sh_byteen got %b expected 1100", obsBe); end
        checks++; if (obsWData !== 32'hABCDABCD) begin errors++; $display("[TB] FAIL sh_wdata got %h expected abcdabcd", obsWData); end
        checks++; if (obsWe !== 1'b1) begin errors++; $display("[TB] FAIL sh_we got %b expected 1", obsWe); end
        checks++; if (obsRData !== 32'h0) begin errors++; $display("[TB] FAIL sh_rdata got %h expected 0", obsRData); end
        // Read and write both set is treated as a store.
        runAccess(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h000000A5, 1, 32'hFFFFFFFF, 1'b0, 1'b0);
        checks++; if ({obsWe, obsBe} !== 5'b10010) begin errors++; $display("[TB] FAIL sb_we_byteen got %b expected 10010", {obsWe, obsBe}); end
        checks++; if (obsWData !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL sb_wdata got %h expected a5a5a5a5", obsWData); end
    endtask

    task automatic test_misaligned;
        int reqSeen;
        logic [1:0]  szTab [3] = '{SZ_WORD, SZ_HALF, 2'b11};
        logic [31:0] adTab [3] = '{32'h102, 32'h101, 32'h100};
        for (int t = 0; t < 3; t++) begin
            iValid = 1'b1; iRead = 1'b1; iWrite = 1'b0; iSize = szTab[t]; iAddr = adTab[t];
            #2;
            checks++; if ({oMisaligned, oStall} !== 2'b10) begin errors++; $display("[TB] FAIL misaligned_%0d mis_stall got %b expected 10", t, {oMisaligned, oStall}); end
            @(posedge clk); #1;
            iValid = 1'b0; iRead = 1'b0;
            reqSeen = 0;
            repeat (3) begin
                #2;
                if (oBusReq || oValid) reqSeen++;
                @(posedge clk); #1;
            end
            checks++; if (reqSeen != 0) begin errors++; $display("[TB] FAIL misaligned_%0d no_access got %0d expected 0", t, reqSeen); end
        end
    endtask

    task automatic test_timeout;
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        checks++; if (obsReq != 8) begin errors++; $display("[TB] FAIL timeout_req_cycles got %0d expected 8", obsReq); end
        checks++; if ({obsDone, obsBusErr} !== 2'b11) begin errors++; $display("[TB] FAIL timeout_valid_err got %b expected 11", {obsDone, obsBusErr}); end
        checks++; if (obsRData !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rdata got %h expected 0", obsRData); end
        checks++; if (obsStall != 9) begin errors++; $display("[TB] FAIL timeout_stall_cycles got %0d expected 9", obsStall); end
        #2;
        checks++; if ({oValid, oBusReq, oStall, oBusError} !== 4'b0) begin errors++; $display("[TB] FAIL late_ack_ignored got %b expected 0000", {oValid, oBusReq, oStall, oBusError}); end
        iBusAck = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bus_error;
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, 2, 32'hCAFEF00D, 1'b1, 1'b0);
        checks++; if ({obsDone, obsBusErr} !== 2'b11) begin errors++; $display("[TB] FAIL buserr_valid_err got %b expected 11", {obsDone, obsBusErr}); end
        checks++; if (obsRData !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL buserr_rdata got %h expected cafef00d", obsRData); end
    endtask

    task automatic test_reset_mid_busy;
        iValid = 1'b1; iRead = 1'b1; iWrite = 1'b0; iSize = SZ_WORD; iSigned = 1'b0; iAddr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        checks++; if (oBusReq !== 1'b1) begin errors++; $display("[TB] FAIL midbusy_req_before got %b expected 1", oBusReq); end
        reset = 1'b0;
        #1;
        checks++; if ({oBusReq, oStall} !== 2'b00) begin errors++; $display("[TB] FAIL midbusy_req_stall got %b expected 00", {oBusReq, oStall}); end
        iValid = 1'b0; iRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, 1, 32'h0BADF00D, 1'b0, 1'b0);
        checks++; if ({obsDone, obsBusErr} !== 2'b10 || obsStall != 2) begin errors++; $display("[TB] FAIL after_reset_access got done_err=%b stall=%0d expected 10 and 2", {obsDone, obsBusErr}, obsStall); end
        checks++; if (obsRData !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL after_reset_rdata got %h expected 0badf00d", obsRData); end
    endtask

    task automatic test_back_to_back;
        runAccess(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 1, 32'h0, 1'b0, 1'b0);
        checks++; if ({obsWe, obsBe} !== 5'b11111 || obsWData !== 32'h11223344) begin errors++; $display("[TB] FAIL b2b_store got we_be=%b wdata=%h expected 11111 11223344", {obsWe, obsBe}, obsWData); end
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 32'h55667788, 1'b0, 1'b0);
        checks++; if (obsRData !== 32'h55667788 || obsStall != 2) begin errors++; $display("[TB] FAIL b2b_load got rdata=%h stall=%0d expected 55667788 and 2", obsRData, obsStall); end
        #2;
        checks++; if ({oStall, oBusReq, oValid} !== 3'b000) begin errors++; $display("[TB] FAIL b2b_idle got %b expected 000", {oStall, oBusReq, oValid}); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_subword_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_reset_mid_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
